// File: rtl/counter_ctrl_debounce_if.sv
// Button inputs and counter-control outputs of the debounce front end.
// master drives the raw buttons and reads the controls; slave is the design side.
interface counter_ctrl_debounce_if;
    logic i_btn_run;
    logic i_btn_dir;
    logic i_btn_step;
    logic o_en;
    logic o_up_down;
    logic o_running;

    modport master (
        output i_btn_run,
        output i_btn_dir,
        output i_btn_step,
        input  o_en,
        input  o_up_down,
        input  o_running
    );

    modport slave (
        input  i_btn_run,
        input  i_btn_dir,
        input  i_btn_step,
        output o_en,
        output o_up_down,
        output o_running
    );
endinterface

// File: rtl/counter_ctrl_debounce.sv
// Debounces the run/dir/step buttons and turns the clean presses into
// registered enable and direction controls for the up/down counter.
module counter_ctrl_debounce #(
    parameter int unsigned DB_CYCLES    = 16,
    parameter bit          RUN_AT_RESET = 1'b1,
    parameter bit          DIR_AT_RESET = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    counter_ctrl_debounce_if.slave  ctrl_if
);

    localparam int unsigned NBTN     = 3;
    localparam int unsigned CW       = 16;
    localparam int unsigned BTN_RUN  = 0;
    localparam int unsigned BTN_DIR  = 1;
    localparam int unsigned BTN_STEP = 2;
    // Transition fires on the cycle the counter steps to DB_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } db_state_e;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] lvl_c;
    logic [NBTN-1:0] lvl_q;
    logic [NBTN-1:0] press_q;
    db_state_e       st_q  [NBTN];
    logic [CW-1:0]   cnt_q [NBTN];

    logic running_q;
    logic running_d;
    logic en_q;
    logic en_d;
    logic dir_q;
    logic dir_d;
    logic run_p;
    logic dir_p;
    logic step_p;

    assign btn_raw = {ctrl_if.i_btn_step, ctrl_if.i_btn_dir, ctrl_if.i_btn_run};

    // Debounced level is high in HIGH and while a fall is still being qualified.
    always_comb begin
        lvl_c = '0;
        for (int unsigned i = 0; i < NBTN; i++) begin
            lvl_c[i] = (st_q[i] == ST_HIGH) || (st_q[i] == ST_FALL);
        end
    end

    // Synchronizers, per-button debounce FSMs and rising-edge press pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            press_q <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                st_q[i]  <= ST_LOW;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_c;
            press_q <= lvl_c & ~lvl_q;
            for (int unsigned i = 0; i < NBTN; i++) begin
                case (st_q[i])
                    ST_LOW: begin
                        if (sync2_q[i]) begin
                            st_q[i]  <= ST_RISE;
                            cnt_q[i] <= '0;
                        end
                    end
                    ST_RISE: begin
                        if (!sync2_q[i]) begin
                            st_q[i] <= ST_LOW;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CW'(1);
                            if (cnt_q[i] == CNT_LAST) begin
                                st_q[i] <= ST_HIGH;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (!sync2_q[i]) begin
                            st_q[i]  <= ST_FALL;
                            cnt_q[i] <= '0;
                        end
                    end
                    ST_FALL: begin
                        if (sync2_q[i]) begin
                            st_q[i] <= ST_HIGH;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CW'(1);
                            if (cnt_q[i] == CNT_LAST) begin
                                st_q[i] <= ST_LOW;
                            end
                        end
                    end
                    default: begin
                        st_q[i] <= ST_LOW;
                    end
                endcase
            end
        end
    end

    assign run_p  = press_q[BTN_RUN];
    assign dir_p  = press_q[BTN_DIR];
    assign step_p = press_q[BTN_STEP];

    // A run toggle on the same cycle swallows a step press.
    always_comb begin
        running_d = running_q ^ run_p;
        dir_d     = dir_q ^ dir_p;
        en_d      = running_d | (step_p & ~running_q & ~run_p);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            running_q <= RUN_AT_RESET;
            en_q      <= RUN_AT_RESET;
            dir_q     <= DIR_AT_RESET;
        end else begin
            running_q <= running_d;
            en_q      <= en_d;
            dir_q     <= dir_d;
        end
    end

    assign ctrl_if.o_en      = en_q;
    assign ctrl_if.o_up_down = dir_q;
    assign ctrl_if.o_running = running_q;

endmodule
